// File: rtl/lcd_pkg.sv
// Shared definitions for the sprite motion controller: screen geometry defaults,
// register map addresses, CTRL/STATUS bit positions and the update FSM state type.
// Imported by sprite_motion_ctrl and axis_step.
package lcd_pkg;

  // Visible-area geometry defaults.
  localparam int SCREEN_W_DEF = 800;
  localparam int SCREEN_H_DEF = 480;
  localparam int SPRITE_DEF   = 64;

  // Register map (3-bit address space; 5..7 are reserved).
  localparam logic [2:0] ADDR_POS_X  = 3'd0;
  localparam logic [2:0] ADDR_POS_Y  = 3'd1;
  localparam logic [2:0] ADDR_VEL    = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  // CTRL bits.
  localparam int CTRL_RUN    = 0;
  localparam int CTRL_BOUNCE = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bits (write-1-to-clear).
  localparam int ST_HIT_X   = 0;
  localparam int ST_HIT_Y   = 1;
  localparam int ST_OVERRUN = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_X  = 2'd1,
    UPD_Y  = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/axis_step.sv
// One-axis position step: new = pos + vel, then bounce (clamp + reflect) or wrap at [0, max_pos].
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
// Ports: pos/vel/max_pos/bounce in; new_pos/new_vel/hit out (hit only ever set when bounce=1).
module axis_step
  import lcd_pkg::*;
(
  input  logic signed [15:0] pos,
  input  logic        [7:0]  vel,
  input  logic signed [15:0] max_pos,
  input  logic               bounce,
  output logic signed [15:0] new_pos,
  output logic        [7:0]  new_vel,
  output logic               hit
);

  logic signed [16:0] sum;
  logic signed [16:0] max_w;
  logic        [7:0]  neg_vel;

  always_comb begin
    // 17-bit sum so an out-of-range written position cannot overflow the compare.
    sum     = {pos[15], pos} + {{9{vel[7]}}, vel};
    max_w   = {max_pos[15], max_pos};
    // -(-128) does not fit in 8 bits; saturate to +127.
    neg_vel = (vel == 8'h80) ? 8'h7F : (~vel + 8'd1);

    new_pos = sum[15:0];
    new_vel = vel;
    hit     = 1'b0;

    if (sum < 17'sd0) begin
      if (bounce) begin
        new_pos = '0;
        new_vel = neg_vel;
        hit     = 1'b1;
      end else begin
        // |vel| <= 128 < max, so one wrap correction is enough.
        new_pos = sum[15:0] + max_pos + 16'sd1;
      end
    end else if (sum > max_w) begin
      if (bounce) begin
        new_pos = max_pos;
        new_vel = neg_vel;
        hit     = 1'b1;
      end else begin
        new_pos = sum[15:0] - max_pos - 16'sd1;
      end
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position sequencer: per frame tick, steps X then Y by the programmed velocity and
// commits both offsets together; CPU register port with valid/ready writes and a level IRQ.
// Latency: frame_tick at cycle T -> offset_x/offset_y change at T+4; rd_data one cycle after rd_en.
// Backpressure: wr_ready is high only in IDLE; writes during an update stall without loss.
// Ports: clk_sys/reset; frame_tick; wr_valid/wr_ready/wr_addr/wr_data; rd_en/rd_addr/rd_data;
//        offset_x/offset_y to scan-out; irq.
module sprite_motion_ctrl
  import lcd_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int SPRITE   = SPRITE_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic        [2:0]  wr_addr,
  input  logic        [15:0] wr_data,
  input  logic               rd_en,
  input  logic        [2:0]  rd_addr,
  output logic        [15:0] rd_data,
  output logic signed [15:0] offset_x,
  output logic signed [15:0] offset_y,
  output logic               irq
);

  localparam logic signed [15:0] MAX_X = 16'(SCREEN_W - SPRITE);
  localparam logic signed [15:0] MAX_Y = 16'(SCREEN_H - SPRITE);

  state_t             state_q, state_d;
  logic signed [15:0] pos_x_q, pos_x_d;
  logic signed [15:0] pos_y_q, pos_y_d;
  logic signed [15:0] off_x_q, off_x_d;
  logic signed [15:0] off_y_q, off_y_d;
  logic        [7:0]  dx_q, dx_d;
  logic        [7:0]  dy_q, dy_d;
  logic        [2:0]  ctrl_q, ctrl_d;
  logic        [2:0]  status_q, status_d;
  logic        [15:0] rd_data_q, rd_data_d;

  logic        [2:0]  status_set;
  logic        [2:0]  status_clr;
  logic               wr_fire;

  // One axis_step shared between the X and Y update cycles.
  logic               sel_y;
  logic signed [15:0] step_pos;
  logic        [7:0]  step_vel;
  logic signed [15:0] step_max;
  logic signed [15:0] step_new_pos;
  logic        [7:0]  step_new_vel;
  logic               step_hit;

  assign sel_y    = (state_q == UPD_Y);
  assign step_pos = sel_y ? pos_y_q : pos_x_q;
  assign step_vel = sel_y ? dy_q    : dx_q;
  assign step_max = sel_y ? MAX_Y   : MAX_X;

  axis_step u_axis_step (
    .pos     (step_pos),
    .vel     (step_vel),
    .max_pos (step_max),
    .bounce  (ctrl_q[CTRL_BOUNCE]),
    .new_pos (step_new_pos),
    .new_vel (step_new_vel),
    .hit     (step_hit)
  );

  assign wr_ready = (state_q == IDLE);
  assign wr_fire  = wr_valid && wr_ready;

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    off_x_d    = off_x_q;
    off_y_d    = off_y_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    ctrl_d     = ctrl_q;
    rd_data_d  = rd_data_q;
    status_set = '0;
    status_clr = '0;

    unique case (state_q)
      IDLE: begin
        if (frame_tick && ctrl_q[CTRL_RUN]) state_d = UPD_X;
      end
      UPD_X: begin
        pos_x_d              = step_new_pos;
        dx_d                 = step_new_vel;
        status_set[ST_HIT_X] = step_hit;
        state_d              = UPD_Y;
      end
      UPD_Y: begin
        pos_y_d              = step_new_pos;
        dy_d                 = step_new_vel;
        status_set[ST_HIT_Y] = step_hit;
        state_d              = COMMIT;
      end
      COMMIT: begin
        // Both offsets move in the same cycle so scan-out never sees a half-updated pair.
        off_x_d = pos_x_q;
        off_y_d = pos_y_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_tick && (state_q != IDLE)) status_set[ST_OVERRUN] = 1'b1;

    // Writes only fire in IDLE, so they never collide with the FSM's own updates.
    if (wr_fire) begin
      unique case (wr_addr)
        ADDR_POS_X: begin
          pos_x_d = wr_data;
          off_x_d = wr_data;
        end
        ADDR_POS_Y: begin
          pos_y_d = wr_data;
          off_y_d = wr_data;
        end
        ADDR_VEL: begin
          dx_d = wr_data[7:0];
          dy_d = wr_data[15:8];
        end
        ADDR_CTRL:   ctrl_d     = wr_data[2:0];
        ADDR_STATUS: status_clr = wr_data[2:0];
        default: ;
      endcase
    end

    // Set wins over a same-cycle clear.
    status_d = (status_q & ~status_clr) | status_set;

    if (rd_en) begin
      unique case (rd_addr)
        ADDR_POS_X:  rd_data_d = pos_x_q;
        ADDR_POS_Y:  rd_data_d = pos_y_q;
        ADDR_VEL:    rd_data_d = {dy_q, dx_q};
        ADDR_CTRL:   rd_data_d = {13'd0, ctrl_q};
        ADDR_STATUS: rd_data_d = {13'd0, status_q};
        default:     rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      off_x_q   <= '0;
      off_y_q   <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      ctrl_q    <= '0;
      status_q  <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      off_x_q   <= off_x_d;
      off_y_q   <= off_y_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign offset_x = off_x_q;
  assign offset_y = off_y_q;
  assign rd_data  = rd_data_q;
  assign irq      = ctrl_q[CTRL_IRQ_EN] && (|status_q);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
module tb_sprite_motion_ctrl;

  logic               clk_sys = 1'b0;
  logic               reset;
  logic               frame_tick;
  logic               wr_valid;
  logic               wr_ready;
  logic        [2:0]  wr_addr;
  logic        [15:0] wr_data;
  logic               rd_en;
  logic        [2:0]  rd_addr;
  logic        [15:0] rd_data;
  logic signed [15:0] offset_x;
  logic signed [15:0] offset_y;
  logic               irq;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  sprite_motion_ctrl dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .frame_tick (frame_tick),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .offset_x   (offset_x),
    .offset_y   (offset_y),
    .irq        (irq)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Single write; only used while the DUT is known to be IDLE.
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    d = rd_data;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    checks++; if (offset_x !== 16'sd0) begin errors++; $display("FAIL reset_off_x got %0d want 0", offset_x); end
    checks++; if (offset_y !== 16'sd0) begin errors++; $display("FAIL reset_off_y got %0d want 0", offset_y); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    rd(3'd4, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL reset_status got %h want 0000", v); end
  endtask

  task automatic test_basic();
    wr(3'd0, 16'd100);
    checks++; if (offset_x !== 16'sd100) begin errors++; $display("FAIL basic_posx_load got %0d want 100", offset_x); end
    wr(3'd1, 16'd50);
    wr(3'd2, 16'hFE03);
    wr(3'd3, 16'h0001);
    pulse_tick();                          // UPD_X
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_rdy_t1 got %b want 0", wr_ready); end
    step();                                // UPD_Y
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_rdy_t2 got %b want 0", wr_ready); end
    step();                                // COMMIT
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL basic_rdy_t3 got %b want 0", wr_ready); end
    checks++; if (offset_x !== 16'sd100) begin errors++; $display("FAIL basic_early_x got %0d want 100", offset_x); end
    step();                                // IDLE, offsets committed
    checks++; if (offset_x !== 16'sd103) begin errors++; $display("FAIL basic_off_x got %0d want 103", offset_x); end
    checks++; if (offset_y !== 16'sd48) begin errors++; $display("FAIL basic_off_y got %0d want 48", offset_y); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL basic_rdy_t4 got %b want 1", wr_ready); end
  endtask

  task automatic test_bounce();
    logic [15:0] v;
    wr(3'd0, 16'd735);
    wr(3'd2, 16'h0005);
    wr(3'd3, 16'h0007);
    pulse_tick();
    step(); step(); step();
    checks++; if (offset_x !== 16'sd736) begin errors++; $display("FAIL bounce_off_x got %0d want 736", offset_x); end
    checks++; if (offset_y !== 16'sd48) begin errors++; $display("FAIL bounce_off_y got %0d want 48", offset_y); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL bounce_irq got %b want 1", irq); end
    rd(3'd2, v);
    checks++; if (v !== 16'h00FB) begin errors++; $display("FAIL bounce_vel got %h want 00fb", v); end
    rd(3'd4, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL bounce_status got %h want 0001", v); end
    wr(3'd4, 16'h0001);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bounce_irq_clr got %b want 0", irq); end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    wr(3'd3, 16'h0001);
    wr(3'd1, 16'd2);
    wr(3'd2, 16'hFB00);
    pulse_tick();
    step(); step(); step();
    checks++; if (offset_y !== 16'sd414) begin errors++; $display("FAIL wrap_off_y got %0d want 414", offset_y); end
    checks++; if (offset_x !== 16'sd736) begin errors++; $display("FAIL wrap_off_x got %0d want 736", offset_x); end
    rd(3'd4, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL wrap_status got %h want 0000", v); end
  endtask

  task automatic test_overrun();
    logic [15:0] v;
    int stall;
    bit acc;
    wr(3'd0, 16'd0);
    wr(3'd1, 16'd0);
    wr(3'd2, 16'h0001);
    wr(3'd3, 16'h0005);
    frame_tick = 1'b1;
    step();                                // now UPD_X, second tick still high
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'd7;
    stall = 0; acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      if (wr_ready) acc = 1'b1;
      else stall++;
      step();
      frame_tick = 1'b0;
    end
    wr_valid = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL ovr_accept_timeout got %b want 1", acc); end
    checks++; if (stall !== 3) begin errors++; $display("FAIL ovr_stall_cycles got %0d want 3", stall); end
    checks++; if (offset_y !== 16'sd7) begin errors++; $display("FAIL ovr_write_y got %0d want 7", offset_y); end
    step(); step(); step(); step(); step(); step();
    checks++; if (offset_x !== 16'sd1) begin errors++; $display("FAIL ovr_single_update got %0d want 1", offset_x); end
    checks++; if (offset_y !== 16'sd7) begin errors++; $display("FAIL ovr_write_once got %0d want 7", offset_y); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq got %b want 1", irq); end
    rd(3'd4, v);
    checks++; if (v !== 16'h0004) begin errors++; $display("FAIL ovr_status got %h want 0004", v); end
    wr(3'd4, 16'h0004);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clr got %b want 0", irq); end
  endtask

  task automatic test_same_cycle_and_reset();
    logic [15:0] v;
    wr(3'd3, 16'h0001);
    wr(3'd2, 16'h0001);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'd10; frame_tick = 1'b1;
    step();                                // write and tick both taken
    wr_valid = 1'b0; frame_tick = 1'b0;
    checks++; if (offset_x !== 16'sd10) begin errors++; $display("FAIL same_write_x got %0d want 10", offset_x); end
    step(); step();
    checks++; if (offset_x !== 16'sd10) begin errors++; $display("FAIL same_pre_commit got %0d want 10", offset_x); end
    step();
    checks++; if (offset_x !== 16'sd11) begin errors++; $display("FAIL same_commit_x got %0d want 11", offset_x); end
    // Reset while in UPD_Y must abort without committing.
    pulse_tick();                          // UPD_X
    step();                                // UPD_Y
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (offset_x !== 16'sd0) begin errors++; $display("FAIL rst_mid_x got %0d want 0", offset_x); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got %b want 1", wr_ready); end
    step(); step(); step();
    checks++; if (offset_x !== 16'sd0) begin errors++; $display("FAIL rst_no_commit_x got %0d want 0", offset_x); end
    checks++; if (offset_y !== 16'sd0) begin errors++; $display("FAIL rst_no_commit_y got %0d want 0", offset_y); end
    rd(3'd2, v);
    checks++; if (v !== 16'h0000) begin errors++; $display("FAIL rst_vel got %h want 0000", v); end
  endtask

  task automatic test_saturation();
    logic [15:0] v;
    wr(3'd0, 16'd50);
    wr(3'd2, 16'h0080);
    wr(3'd3, 16'h0003);
    pulse_tick();
    step(); step(); step();
    checks++; if (offset_x !== 16'sd0) begin errors++; $display("FAIL sat_off_x got %0d want 0", offset_x); end
    checks++; if (offset_y !== 16'sd0) begin errors++; $display("FAIL sat_off_y got %0d want 0", offset_y); end
    rd(3'd2, v);
    checks++; if (v !== 16'h007F) begin errors++; $display("FAIL sat_vel got %h want 007f", v); end
    rd(3'd4, v);
    checks++; if (v !== 16'h0001) begin errors++; $display("FAIL sat_status got %h want 0001", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sat_irq_masked got %b want 0", irq); end
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    test_reset();
    test_basic();
    test_bounce();
    test_wrap();
    test_overrun();
    test_same_cycle_and_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
